// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list reader: fetch states,
// word decode codes and the bit layout of a vector word {x, y, line, pos}.
package vector_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        LATCH     = 3'd2,
        DECODE    = 3'd3,
        WAIT_LINE = 3'd4,
        FINISH    = 3'd5
    } fetch_state_e;

    // {line, pos} field values
    localparam logic [1:0] CODE_NOP  = 2'b00;
    localparam logic [1:0] CODE_MOVE = 2'b01;
    localparam logic [1:0] CODE_DRAW = 2'b10;
    localparam logic [1:0] CODE_END  = 2'b11;

    localparam int POS_BIT  = 0;
    localparam int LINE_BIT = 1;
    localparam int Y_LSB    = 2;

    // x sits directly above the y field, whose width depends on the coordinate width
    function automatic int x_lsb(input int out_width);
        return Y_LSB + out_width;
    endfunction

endpackage

// File: rtl/vector_fetch.sv
// Walks the vector display list in frame RAM from address 0, tracks the pen
// and hands line segments to the line drawer; reports frame end via halt.
module vector_fetch
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int ADR_WIDTH = 16,
    parameter int DATAWIDTH = 2*OUT_WIDTH+2,
    parameter int ADR_LAST  = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 halt,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic [OUT_WIDTH-1:0] x0,
    output logic [OUT_WIDTH-1:0] y0,
    output logic [OUT_WIDTH-1:0] x1,
    output logic [OUT_WIDTH-1:0] y1,
    output logic                 line_start,
    input  logic                 line_busy,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int                   X_LSB      = x_lsb(OUT_WIDTH);
    localparam logic [ADR_WIDTH-1:0] ADR_LAST_V = ADR_WIDTH'(ADR_LAST);
    localparam logic [ADR_WIDTH-1:0] ADR_ONE    = ADR_WIDTH'(1);

    fetch_state_e           state_r;
    fetch_state_e           state_next_s;
    logic [DATAWIDTH-1:0]   word_r;
    logic [OUT_WIDTH-1:0]   pen_x_r;
    logic [OUT_WIDTH-1:0]   pen_y_r;
    logic [OUT_WIDTH-1:0]   word_x_s;
    logic [OUT_WIDTH-1:0]   word_y_s;
    logic [1:0]             code_s;
    logic                   go_armed_r;
    logic                   start_s;
    logic                   issue_s;
    logic                   move_s;
    logic                   advance_s;
    logic                   end_s;
    logic                   at_last_s;

    assign word_x_s  = word_r[X_LSB +: OUT_WIDTH];
    assign word_y_s  = word_r[Y_LSB +: OUT_WIDTH];
    assign code_s    = {word_r[LINE_BIT], word_r[POS_BIT]};
    assign at_last_s = (adrREAD == ADR_LAST_V);
    // go_armed blocks a restart on a go level left high from the previous frame
    assign start_s   = (state_r == IDLE) && go && go_armed_r;

    // Next-state and per-cycle action decode
    always_comb begin
        issue_s      = 1'b0;
        move_s       = 1'b0;
        advance_s    = 1'b0;
        end_s        = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ:    state_next_s = LATCH;
            LATCH:  state_next_s = DECODE;
            DECODE: begin
                case (code_s)
                    CODE_END: begin
                        end_s        = 1'b1;
                        state_next_s = FINISH;
                    end
                    CODE_DRAW: begin
                        if (line_busy) begin
                            state_next_s = WAIT_LINE;
                        end else begin
                            issue_s   = 1'b1;
                            advance_s = 1'b1;
                        end
                    end
                    CODE_MOVE: begin
                        move_s    = 1'b1;
                        advance_s = 1'b1;
                    end
                    default: advance_s = 1'b1;
                endcase
            end
            WAIT_LINE: begin
                if (line_busy) begin
                    state_next_s = WAIT_LINE;
                end else begin
                    issue_s   = 1'b1;
                    advance_s = 1'b1;
                end
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        // The last readable address never wraps: it ends the frame as an abort
        if (advance_s) begin
            if (at_last_s) begin
                state_next_s = FINISH;
            end else begin
                state_next_s = REQ;
            end
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Registered state, address, pen and segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            halt       <= 1'b1;
            adrREAD    <= '0;
            word_r     <= '0;
            pen_x_r    <= '0;
            pen_y_r    <= '0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            line_start <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            go_armed_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            line_start <= issue_s;
            frame_done <= end_s || (advance_s && at_last_s);

            if (!go) begin
                go_armed_r <= 1'b1;
            end else if (start_s) begin
                go_armed_r <= 1'b0;
            end

            if (start_s) begin
                halt <= 1'b0;
            end else if (state_r == FINISH) begin
                halt <= 1'b1;
            end

            if (state_r == IDLE) begin
                adrREAD <= '0;
            end else if (advance_s && !at_last_s) begin
                adrREAD <= adrREAD + ADR_ONE;
            end

            if (advance_s && at_last_s) begin
                overflow <= 1'b1;
            end

            if (state_r == LATCH) begin
                word_r <= dataREAD;
            end

            if (issue_s) begin
                x0 <= pen_x_r;
                y0 <= pen_y_r;
                x1 <= word_x_s;
                y1 <= word_y_s;
            end

            if (start_s) begin
                pen_x_r <= '0;
                pen_y_r <= '0;
            end else if (issue_s || move_s) begin
                pen_x_r <= word_x_s;
                pen_y_r <= word_y_s;
            end
        end
    end

endmodule

// File: tb/tb_vector_fetch.sv
// Scoreboard bench for vector_fetch: a list-walking reference model queues the
// expected segments and frame end; a monitor pops and compares on each pulse.
module tb_vector_fetch;
    import vector_pkg::*;

    localparam int OW = 8;
    localparam int AW = 16;
    localparam int DW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, go, line_busy;
    logic          halt, line_start, frame_done, overflow;
    logic [AW-1:0] adr_read;
    logic [DW-1:0] data_read;
    logic [OW-1:0] x0, y0, x1, y1;
    logic [DW-1:0] ram [0:15];

    logic          go_b, halt_b, line_start_b, frame_done_b, overflow_b;
    logic          line_busy_b;
    logic [AW-1:0] adr_read_b;
    logic [DW-1:0] data_read_b;
    logic [OW-1:0] x0_b, y0_b, x1_b, y1_b;
    logic [DW-1:0] ram_b [0:15];

    int checks = 0;
    int errors = 0;

    vector_fetch dut (
        .clk(clk), .rst(rst), .go(go), .halt(halt), .adrREAD(adr_read),
        .dataREAD(data_read), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .line_start(line_start), .line_busy(line_busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    vector_fetch #(.ADR_LAST(3)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .halt(halt_b), .adrREAD(adr_read_b),
        .dataREAD(data_read_b), .x0(x0_b), .y0(y0_b), .x1(x1_b), .y1(y1_b),
        .line_start(line_start_b), .line_busy(line_busy_b),
        .frame_done(frame_done_b), .overflow(overflow_b)
    );

    function automatic logic [DW-1:0] mk(input logic [7:0] x, input logic [7:0] y, input logic [1:0] c);
        return {x, y, c};
    endfunction

    // Synchronous RAMs; out-of-range reads return an end marker
    always @(posedge clk) begin
        data_read   <= (adr_read < 16)   ? ram[adr_read[3:0]]     : mk(8'd0, 8'd0, CODE_END);
        data_read_b <= (adr_read_b < 16) ? ram_b[adr_read_b[3:0]] : mk(8'd0, 8'd0, CODE_END);
    end

    typedef struct {
        bit         is_end;
        bit         ovf;
        logic [7:0] sx0, sy0, sx1, sy1;
    } exp_t;
    exp_t sb[$];

    // Reference: walk the list, pen starts at the origin each frame
    task automatic model_frame();
        logic [7:0] px, py, wx, wy;
        logic [1:0] c;
        exp_t e;
        px = 8'd0; py = 8'd0;
        for (int a = 0; a < 16; a++) begin
            {wx, wy, c} = ram[a];
            if (c == CODE_END) begin
                e = '{is_end: 1'b1, ovf: 1'b0, sx0: 8'd0, sy0: 8'd0, sx1: 8'd0, sy1: 8'd0};
                sb.push_back(e);
                break;
            end
            if (c == CODE_DRAW) begin
                e = '{is_end: 1'b0, ovf: 1'b0, sx0: px, sy0: py, sx1: wx, sy1: wy};
                sb.push_back(e);
            end
            if (c != CODE_NOP) begin
                px = wx; py = wy;
            end
        end
    endtask

    // Line drawer stand-in: busy for a while after each accepted segment
    int busy_hold   = 0;
    bit busy_random = 1'b0;
    int busy_cnt    = 0;
    logic busy_sampled = 1'b0;
    initial line_busy = 1'b0;
    always @(posedge clk) busy_sampled = line_busy;
    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt--;
        if (line_start && busy_hold > 0)
            busy_cnt = busy_random ? int'($urandom_range(0, busy_hold)) : busy_hold;
        line_busy = (busy_cnt > 0);
    end

    // Monitor: compare every pulse against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (line_start) begin
                checks++;
                if (busy_sampled) begin
                    errors++;
                    $display("FAIL busy_gate: line_start issued with line_busy=%0b, required 0", busy_sampled);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL segment: unexpected line_start (%0d,%0d)->(%0d,%0d), required none", x0, y0, x1, y1);
                end else begin
                    e = sb.pop_front();
                    if (e.is_end || x0 !== e.sx0 || y0 !== e.sy0 || x1 !== e.sx1 || y1 !== e.sy1) begin
                        errors++;
                        $display("FAIL segment: got (%0d,%0d)->(%0d,%0d) required (%0d,%0d)->(%0d,%0d) end_expected=%0b",
                                 x0, y0, x1, y1, e.sx0, e.sy0, e.sx1, e.sy1, e.is_end);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done: unexpected pulse, required none");
                end else begin
                    e = sb.pop_front();
                    if (!e.is_end || overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL frame_done: got overflow=%0b required end with overflow=%0b (end_expected=%0b)",
                                 overflow, e.ovf, e.is_end);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Re-arm go, start a frame and wait for its end (optionally checking latency)
    task automatic run_frame(input int exp_cycles);
        int cyc, start_cyc;
        bit done;
        model_frame();
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        cyc = 0; start_cyc = -1; done = 1'b0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (!halt && start_cyc < 0) start_cyc = cyc;
            if (frame_done) done = 1'b1;
        end
        check("frame_completes", 32'(done), 32'd1);
        check("halt_went_low", 32'(start_cyc >= 0), 32'd1);
        if (done && exp_cycles >= 0) check("frame_latency", 32'(cyc - start_cyc), 32'(exp_cycles));
        @(negedge clk);
        check("halt_after_frame", 32'(halt), 32'd1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, cyc, max_adr, ls_cnt;
        bit done, halt_low;
        rst = 1'b1; go = 1'b0; go_b = 1'b0; line_busy_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = mk(8'd0, 8'd0, CODE_END);
            ram_b[i] = mk(8'd0, 8'd0, CODE_END);
        end
        repeat (3) @(negedge clk);
        check("rst_halt", 32'(halt), 32'd1);
        check("rst_adr", 32'(adr_read), 32'd0);
        check("rst_coords", {x0, y0, x1, y1}, 32'd0);
        check("rst_pulses", {30'd0, line_start, frame_done}, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic list: two segments, 12-cycle frame
        ram[0] = mk(8'd10, 8'd20, CODE_MOVE);
        ram[1] = mk(8'd50, 8'd20, CODE_DRAW);
        ram[2] = mk(8'd50, 8'd60, CODE_DRAW);
        ram[3] = mk(8'd0,  8'd0,  CODE_END);
        run_frame(12);

        // Stale go: stays high, no new frame
        halt_low = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!halt) halt_low = 1'b1;
        end
        check("stale_go_no_restart", 32'(halt_low), 32'd0);

        // Same list with a long busy after the first segment
        busy_hold = 20; busy_random = 1'b0;
        run_frame(-1);
        busy_hold = 0;
        repeat (25) @(negedge clk);

        // nop then draw from the implicit origin
        ram[0] = mk(8'd9, 8'd9, CODE_NOP);
        ram[1] = mk(8'd5, 8'd5, CODE_DRAW);
        ram[2] = mk(8'd0, 8'd0, CODE_END);
        run_frame(9);
        check("no_overflow", 32'(overflow), 32'd0);

        // Abort at the last address on the small-address instance
        ram_b[0] = mk(8'd1, 8'd2, CODE_MOVE);
        ram_b[1] = mk(8'd3, 8'd4, CODE_DRAW);
        ram_b[2] = mk(8'd0, 8'd0, CODE_NOP);
        ram_b[3] = mk(8'd7, 8'd8, CODE_DRAW);
        go_b = 1'b0;
        @(negedge clk);
        go_b = 1'b1;
        cyc = 0; done = 1'b0; max_adr = 0; ls_cnt = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (int'(adr_read_b) > max_adr) max_adr = int'(adr_read_b);
            if (line_start_b) ls_cnt++;
            if (frame_done_b) begin
                done = 1'b1;
                check("abort_overflow_at_done", 32'(overflow_b), 32'd1);
            end
        end
        check("abort_done", 32'(done), 32'd1);
        check("abort_max_adr", 32'(max_adr), 32'd3);
        check("abort_segments", 32'(ls_cnt), 32'd2);
        check("abort_last_seg", {x0_b, y0_b, x1_b, y1_b}, {8'd3, 8'd4, 8'd7, 8'd8});
        repeat (5) @(negedge clk);
        check("overflow_sticky", 32'(overflow_b), 32'd1);
        check("abort_halt", 32'(halt_b), 32'd1);

        // Reset while waiting on the line drawer
        ram[0] = mk(8'd10, 8'd20, CODE_MOVE);
        ram[1] = mk(8'd50, 8'd20, CODE_DRAW);
        ram[2] = mk(8'd50, 8'd60, CODE_DRAW);
        ram[3] = mk(8'd0,  8'd0,  CODE_END);
        busy_hold = 20; busy_random = 1'b0;
        model_frame();
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        cyc = 0;
        while (!line_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("first_seg_before_rst", 32'(line_start), 32'd1);
        repeat (6) @(negedge clk);
        #1;
        busy_hold = 0; busy_cnt = 0; line_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("rst_mid_halt", 32'(halt), 32'd1);
        check("rst_mid_adr", 32'(adr_read), 32'd0);
        check("rst_mid_no_line_start", 32'(line_start), 32'd0);
        check("rst_clears_overflow", 32'(overflow_b), 32'd0);
        repeat (3) @(negedge clk);
        check("no_restart_without_rearm", 32'(halt), 32'd1);
        run_frame(12);

        // Randomised lists with random drawer busy times
        for (int n = 0; n < 10; n++) begin
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len - 1; i++)
                ram[i] = mk(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
            ram[len-1] = mk(8'($urandom), 8'($urandom), CODE_END);
            busy_hold   = int'($urandom_range(0, 8));
            busy_random = 1'b1;
            run_frame(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
